// File: rtl/i2c_pkg.sv
// Shared I2C definitions: field widths, FSM state codes and line-event bundle.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    // Target FSM state codes (plain constants so older tools can share them)
    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_ADDR    = 4'd1;
    localparam logic [3:0] ST_ACK_A   = 4'd2;
    localparam logic [3:0] ST_REG     = 4'd3;
    localparam logic [3:0] ST_ACK_R   = 4'd4;
    localparam logic [3:0] ST_WR      = 4'd5;
    localparam logic [3:0] ST_ACK_W   = 4'd6;
    localparam logic [3:0] ST_RD_LOAD = 4'd7;
    localparam logic [3:0] ST_RD      = 4'd8;
    localparam logic [3:0] ST_ACK_M   = 4'd9;

    // Bus events derived from the synchronized SCL/SDA lines
    typedef struct packed {
        logic scl_rise;
        logic scl_fall;
        logic start;
        logic stop;
    } i2c_evt_t;

    // True when the address byte (addr + R/W bit) selects dev_addr
    function automatic logic addr_match(input logic [I2C_BYTE_W-1:0] addr_byte,
                                        input logic [I2C_ADDR_W-1:0] dev_addr);
        return addr_byte[I2C_BYTE_W-1:1] == dev_addr;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into the clk domain and reports SCL edges and
// START/STOP conditions, one clk wide each.
module i2c_line_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
)(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     scl,
    input  logic     sda,
    output logic     sda_s,
    output i2c_evt_t evt
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_hist;
    logic                   r_sda_hist;

    logic w_scl_s;
    logic w_sda_s;
    logic w_sda_rise;
    logic w_sda_fall;

    // Synchronizer chains plus one history flop; reset to the idle (high) bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
            r_scl_hist <= w_scl_s;
            r_sda_hist <= w_sda_s;
        end
    end

    assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
    assign w_sda_rise = w_sda_s & ~r_sda_hist;
    assign w_sda_fall = ~w_sda_s & r_sda_hist;

    assign sda_s = w_sda_s;
    assign evt   = '{scl_rise: w_scl_s & ~r_scl_hist,
                     scl_fall: ~w_scl_s & r_scl_hist,
                     start:    w_sda_fall & w_scl_s,
                     stop:     w_sda_rise & w_scl_s};

endmodule

// File: rtl/i2c_slave.sv
// I2C target bridging [addr][reg pointer][data...] writes and pointer-based
// reads onto a simple register-bank port. Never stretches SCL.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h42,
    parameter int                    SYNC_STAGES = 2
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl,
    inout  wire                   sda,
    output logic [I2C_BYTE_W-1:0] reg_addr,
    output logic                  wr_en,
    output logic [I2C_BYTE_W-1:0] wr_data,
    output logic                  rd_en,
    input  logic [I2C_BYTE_W-1:0] rd_data,
    output logic                  busy,
    output logic                  addr_hit
);

    logic [3:0]            r_state;
    logic [I2C_BYTE_W-1:0] r_shift;
    logic [2:0]            r_bit_cnt;
    logic                  r_ack_on;    // ACK low currently being driven
    logic                  r_rw;        // R/W bit of the matched address byte
    logic                  r_rd_done;   // all 8 read bits have been put on the bus
    logic [1:0]            r_ld_phase;
    logic                  r_sda_oe;
    logic [I2C_BYTE_W-1:0] r_reg_addr;
    logic                  r_wr_en;
    logic [I2C_BYTE_W-1:0] r_wr_data;
    logic                  r_rd_en;
    logic                  r_busy;
    logic                  r_addr_hit;

    logic                  w_sda_s;
    i2c_evt_t              w_evt;
    logic [I2C_BYTE_W-1:0] w_byte;
    logic                  w_last_bit;

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .scl   (scl),
        .sda   (sda),
        .sda_s (w_sda_s),
        .evt   (w_evt)
    );

    // Byte as it will look once the bit on the current SCL rise is shifted in
    assign w_byte     = {r_shift[I2C_BYTE_W-2:0], w_sda_s};
    assign w_last_bit = (r_bit_cnt == 3'd7);

    // Open-drain: only ever pull low
    assign sda = r_sda_oe ? 1'b0 : 1'bz;

    // Protocol FSM; START/STOP override any bit-level activity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_ack_on   <= 1'b0;
            r_rw       <= 1'b0;
            r_rd_done  <= 1'b0;
            r_ld_phase <= '0;
            r_sda_oe   <= 1'b0;
            r_reg_addr <= '0;
            r_wr_en    <= 1'b0;
            r_wr_data  <= '0;
            r_rd_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_addr_hit <= 1'b0;
        end else begin
            r_wr_en    <= 1'b0;
            r_rd_en    <= 1'b0;
            r_addr_hit <= 1'b0;
            if (w_evt.stop) begin
                r_state  <= ST_IDLE;
                r_busy   <= 1'b0;
                r_sda_oe <= 1'b0;
                r_ack_on <= 1'b0;
            end else if (w_evt.start) begin
                r_state   <= ST_ADDR;
                r_bit_cnt <= '0;
                r_sda_oe  <= 1'b0;
                r_ack_on  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                    end
                    ST_ADDR: begin
                        if (w_evt.scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                if (addr_match(w_byte, SLAVE_ADDR)) begin
                                    r_addr_hit <= 1'b1;
                                    r_busy     <= 1'b1;
                                    r_rw       <= w_byte[0];
                                    r_state    <= ST_ACK_A;
                                end else begin
                                    r_state <= ST_IDLE;
                                end
                            end
                        end
                    end
                    ST_ACK_A: begin
                        // A read leaves the ACK driven and preloads the first byte
                        // during the ACK high phase so bit 7 goes out on the next fall
                        if (w_evt.scl_fall && !r_ack_on) begin
                            r_sda_oe <= 1'b1;
                            r_ack_on <= 1'b1;
                        end else if (w_evt.scl_fall && !r_rw) begin
                            r_sda_oe  <= 1'b0;
                            r_ack_on  <= 1'b0;
                            r_bit_cnt <= '0;
                            r_state   <= ST_REG;
                        end else if (w_evt.scl_rise && r_ack_on && r_rw) begin
                            r_ack_on   <= 1'b0;
                            r_ld_phase <= '0;
                            r_state    <= ST_RD_LOAD;
                        end
                    end
                    ST_REG: begin
                        if (w_evt.scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                r_reg_addr <= w_byte;
                                r_state    <= ST_ACK_R;
                            end
                        end
                    end
                    ST_ACK_R: begin
                        if (w_evt.scl_fall) begin
                            r_sda_oe <= ~r_ack_on;
                            r_ack_on <= ~r_ack_on;
                            if (r_ack_on) begin
                                r_bit_cnt <= '0;
                                r_state   <= ST_WR;
                            end
                        end
                    end
                    ST_WR: begin
                        if (w_evt.scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                r_wr_data <= w_byte;
                                r_wr_en   <= 1'b1;
                                r_state   <= ST_ACK_W;
                            end
                        end
                    end
                    ST_ACK_W: begin
                        if (w_evt.scl_fall) begin
                            r_sda_oe <= ~r_ack_on;
                            r_ack_on <= ~r_ack_on;
                            if (r_ack_on) begin
                                r_reg_addr <= r_reg_addr + 8'd1;
                                r_bit_cnt  <= '0;
                                r_state    <= ST_WR;
                            end
                        end
                    end
                    ST_RD_LOAD: begin
                        // phase 0: strobe, phase 1: bank registers data, phase 2: capture
                        case (r_ld_phase)
                            2'd0: begin
                                r_rd_en    <= 1'b1;
                                r_ld_phase <= 2'd1;
                            end
                            2'd1: begin
                                r_ld_phase <= 2'd2;
                            end
                            default: begin
                                r_shift    <= rd_data;
                                r_bit_cnt  <= '0;
                                r_rd_done  <= 1'b0;
                                r_ld_phase <= '0;
                                r_state    <= ST_RD;
                            end
                        endcase
                    end
                    ST_RD: begin
                        if (w_evt.scl_fall) begin
                            if (r_rd_done) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= ST_ACK_M;
                            end else begin
                                r_sda_oe  <= ~r_shift[I2C_BYTE_W-1];
                                r_shift   <= {r_shift[I2C_BYTE_W-2:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                                r_rd_done <= w_last_bit;
                            end
                        end
                    end
                    ST_ACK_M: begin
                        // NACK ends the read but busy holds until the STOP
                        if (w_evt.scl_rise) begin
                            if (!w_sda_s) begin
                                r_reg_addr <= r_reg_addr + 8'd1;
                                r_ld_phase <= '0;
                                r_state    <= ST_RD_LOAD;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign reg_addr = r_reg_addr;
    assign wr_en    = r_wr_en;
    assign wr_data  = r_wr_data;
    assign rd_en    = r_rd_en;
    assign busy     = r_busy;
    assign addr_hit = r_addr_hit;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, pulled-up SDA, register bank
// and a pointer/memory reference model.
module tb_i2c_slave;

    localparam int Q  = 4;   // quarter SCL period in clks (SCL = clk/16)
    localparam int NV = 5;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       scl      = 1'b1;
    logic       m_sda_oe = 1'b0;
    wire        sda;
    logic [7:0] reg_addr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data  = 8'h00;
    logic       busy;
    logic       addr_hit;

    logic [7:0] bank [256];
    logic       host_we   = 1'b0;
    logic [7:0] host_addr = 8'h00;
    logic [7:0] host_data = 8'h00;
    int         n_wr  = 0;
    int         n_rd  = 0;
    int         n_hit = 0;

    int         checks   = 0;
    int         failures = 0;

    logic [7:0] ref_mem [256];
    logic [7:0] ref_ptr = 8'h00;
    logic [7:0] wbuf [4];
    logic [7:0] rbuf [4];
    logic [7:0] ebuf [4];

    typedef struct {
        logic [6:0] dev;
        logic [7:0] ptr;
        int         n;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       exp_ack;
        int         exp_wr;
        logic [7:0] exp_ptr;
        logic [7:0] exp_a0;
        logic [7:0] exp_a1;
    } wvec_t;

    wvec_t vecs [NV];

    always #5 clk = ~clk;

    pullup (sda);
    assign sda = m_sda_oe ? 1'b0 : 1'bz;

    i2c_slave #(
        .SLAVE_ADDR  (7'h42),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl      (scl),
        .sda      (sda),
        .reg_addr (reg_addr),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .busy     (busy),
        .addr_hit (addr_hit)
    );

    // Register bank: host preload port, DUT write port, registered read
    always @(posedge clk) begin
        if (host_we)
            bank[host_addr] <= host_data;
        else if (wr_en)
            bank[reg_addr] <= wr_data;
        if (rd_en)
            rd_data <= bank[reg_addr];
    end

    // Strobe counters
    always @(posedge clk) begin
        if (wr_en)    n_wr  <= n_wr + 1;
        if (rd_en)    n_rd  <= n_rd + 1;
        if (addr_hit) n_hit <= n_hit + 1;
    end

    // Hang guard
    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        host_addr = a;
        host_data = d;
        host_we   = 1'b1;
        ref_mem[a] = d;
        @(negedge clk);
        host_we   = 1'b0;
    endtask

    task automatic bus_start();
        m_sda_oe = 1'b0; wait_clk(Q);
        scl      = 1'b1; wait_clk(Q);
        m_sda_oe = 1'b1; wait_clk(Q);
        scl      = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        m_sda_oe = 1'b1; wait_clk(Q);
        scl      = 1'b1; wait_clk(Q);
        m_sda_oe = 1'b0; wait_clk(2 * Q);
    endtask

    task automatic wbit(input logic b);
        m_sda_oe = ~b; wait_clk(Q);
        scl      = 1'b1; wait_clk(2 * Q);
        scl      = 1'b0; wait_clk(Q);
    endtask

    task automatic rbit(output logic b);
        m_sda_oe = 1'b0; wait_clk(Q);
        scl      = 1'b1; wait_clk(Q);
        b        = sda;  wait_clk(Q);
        scl      = 1'b0; wait_clk(Q);
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        logic a;
        for (int i = 7; i >= 0; i--) wbit(b[i]);
        rbit(a);
        ack = ~a;
    endtask

    task automatic rbyte(output logic [7:0] b, input logic ack);
        logic x;
        b = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            rbit(x);
            b[i] = x;
        end
        wbit(~ack);
    endtask

    // [dev+W][ptr][wbuf 0..n-1] STOP; stops early if the address is not ACKed
    task automatic xfer_write(input logic [6:0] dev, input logic [7:0] ptr, input int n,
                              output logic ack, output logic busy_mid);
        logic a;
        bus_start();
        wbyte({dev, 1'b0}, ack);
        if (ack) begin
            wbyte(ptr, a);
            chk("ptr_ack", a, 1);
            for (int i = 0; i < n; i++) begin
                wbyte(wbuf[i], a);
                chk("data_ack", a, 1);
            end
        end
        busy_mid = busy;
        bus_stop();
    endtask

    // [0x42+W][ptr] Sr [0x42+R] n bytes (ACK all but last) STOP
    task automatic do_read(input logic [7:0] ptr, input int n, output logic busy_mid);
        logic a;
        bus_start();
        wbyte({7'h42, 1'b0}, a);
        chk("rd_addrw_ack", a, 1);
        wbyte(ptr, a);
        chk("rd_ptr_ack", a, 1);
        bus_start();
        wbyte({7'h42, 1'b1}, a);
        chk("rd_addrr_ack", a, 1);
        for (int i = 0; i < n; i++) rbyte(rbuf[i], i != n - 1);
        busy_mid = busy;
        bus_stop();
    endtask

    // Reference: a matched write sets the pointer, stores bytes, pointer +1 each
    task automatic model_write(input logic [6:0] dev, input logic [7:0] ptr, input int n);
        if (dev == 7'h42) begin
            ref_ptr = ptr;
            for (int i = 0; i < n; i++) begin
                ref_mem[ref_ptr] = wbuf[i];
                ref_ptr = ref_ptr + 8'd1;
            end
        end
    endtask

    // Reference: read returns successive bytes; pointer advances on master ACK only
    task automatic model_read(input logic [7:0] ptr, input int n);
        ref_ptr = ptr;
        for (int i = 0; i < n; i++) begin
            ebuf[i] = ref_mem[ref_ptr];
            if (i != n - 1) ref_ptr = ref_ptr + 8'd1;
        end
    endtask

    initial begin
        logic       ack;
        logic       bm;
        logic       b;
        int         w0, h0, r0, n;
        logic [7:0] p;

        vecs[0] = '{7'h42, 8'h10, 2, 8'hA5, 8'h5A, 1'b1, 2, 8'h12, 8'h10, 8'h11};
        vecs[1] = '{7'h43, 8'h10, 2, 8'h77, 8'h88, 1'b0, 0, 8'h12, 8'h10, 8'h11};
        vecs[2] = '{7'h42, 8'hFF, 2, 8'h11, 8'h22, 1'b1, 2, 8'h01, 8'hFF, 8'h00};
        vecs[3] = '{7'h42, 8'h30, 0, 8'h00, 8'h00, 1'b1, 0, 8'h30, 8'h30, 8'h31};
        vecs[4] = '{7'h42, 8'h7E, 1, 8'h9C, 8'h00, 1'b1, 1, 8'h7F, 8'h7E, 8'h7F};

        // Reset values
        wait_clk(4);
        chk("rst_sda",      sda,      1);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_wr_en",    wr_en,    0);
        chk("rst_wr_data",  wr_data,  0);
        chk("rst_rd_en",    rd_en,    0);
        chk("rst_busy",     busy,     0);
        chk("rst_addr_hit", addr_hit, 0);

        for (int i = 0; i < 256; i++) host_write(8'(i), 8'(i * 37 + 11));
        host_write(8'h20, 8'h3C);
        host_write(8'h21, 8'hC3);
        host_write(8'h40, 8'hE7);
        rst_n = 1'b1;
        wait_clk(8);

        // Table-driven write transactions
        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < 4; i++) wbuf[i] = 8'h00;
            wbuf[0] = vecs[v].d0;
            wbuf[1] = vecs[v].d1;
            w0 = n_wr;
            h0 = n_hit;
            model_write(vecs[v].dev, vecs[v].ptr, vecs[v].n);
            xfer_write(vecs[v].dev, vecs[v].ptr, vecs[v].n, ack, bm);
            wait_clk(2);
            $display("txn vec%0d: write dev=%02h ptr=%02h n=%0d ack=%0b reg_addr=%02h",
                     v, vecs[v].dev, vecs[v].ptr, vecs[v].n, ack, reg_addr);
            chk("vec_ack",      ack,          vecs[v].exp_ack);
            chk("vec_busy_mid", bm,           vecs[v].exp_ack);
            chk("vec_wr_cnt",   n_wr - w0,    vecs[v].exp_wr);
            chk("vec_hit_cnt",  n_hit - h0,   {31'd0, vecs[v].exp_ack});
            chk("vec_reg_addr", reg_addr,     vecs[v].exp_ptr);
            chk("vec_model_ptr", reg_addr,    ref_ptr);
            chk("vec_busy_end", busy,         0);
            chk("vec_sda_end",  sda,          1);
            if (vecs[v].exp_wr >= 1) chk("vec_land0", bank[vecs[v].exp_a0], vecs[v].d0);
            if (vecs[v].exp_wr >= 2) chk("vec_land1", bank[vecs[v].exp_a1], vecs[v].d1);
            chk("vec_mem0", bank[vecs[v].exp_a0], ref_mem[vecs[v].exp_a0]);
            chk("vec_mem1", bank[vecs[v].exp_a1], ref_mem[vecs[v].exp_a1]);
        end

        // Pointer write, repeated START, read two bytes (ACK, NACK)
        r0 = n_rd;
        do_read(8'h20, 2, bm);
        wait_clk(2);
        $display("txn read20: got %02h %02h reg_addr=%02h", rbuf[0], rbuf[1], reg_addr);
        chk("rd_byte0",     rbuf[0],   8'h3C);
        chk("rd_byte1",     rbuf[1],   8'hC3);
        chk("rd_en_cnt",    n_rd - r0, 2);
        chk("rd_busy_nack", bm,        1);
        chk("rd_reg_addr",  reg_addr,  8'h21);
        chk("rd_busy_end",  busy,      0);
        ref_ptr = 8'h21;

        // Reset asserted while the target drives the 4th read bit (a 0)
        bus_start();
        wbyte({7'h42, 1'b0}, ack);
        wbyte(8'h40, ack);
        bus_start();
        wbyte({7'h42, 1'b1}, ack);
        chk("mr_addr_ack", ack, 1);
        for (int i = 0; i < 3; i++) begin
            rbit(b);
            chk("mr_bit", b, 1);
        end
        chk("mr_drive_before_rst", sda, 0);
        rst_n = 1'b0;
        #1;
        chk("mr_sda_released", sda,      1);
        chk("mr_reg_addr",     reg_addr, 0);
        chk("mr_wr_data",      wr_data,  0);
        chk("mr_busy",         busy,     0);
        chk("mr_rd_en",        rd_en,    0);
        wait_clk(3);
        rst_n    = 1'b1;
        m_sda_oe = 1'b0;
        scl      = 1'b1;
        wait_clk(8);
        $display("txn midread_reset: sda=%0b reg_addr=%02h", sda, reg_addr);
        wbuf[0] = 8'h99;
        model_write(7'h42, 8'h55, 1);
        xfer_write(7'h42, 8'h55, 1, ack, bm);
        wait_clk(2);
        $display("txn post_reset_write: ack=%0b reg_addr=%02h", ack, reg_addr);
        chk("pr_ack",      ack,       1);
        chk("pr_land",     bank[8'h55], 8'h99);
        chk("pr_reg_addr", reg_addr,  8'h56);

        // STOP in the middle of a data byte
        w0 = n_wr;
        bus_start();
        wbyte({7'h42, 1'b0}, ack);
        wbyte(8'h60, ack);
        wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b1);
        bus_stop();
        wait_clk(2);
        ref_ptr = 8'h60;
        $display("txn stop_midbyte: reg_addr=%02h busy=%0b", reg_addr, busy);
        chk("sm_wr_cnt",   n_wr - w0,   0);
        chk("sm_busy",     busy,        0);
        chk("sm_sda",      sda,         1);
        chk("sm_reg_addr", reg_addr,    8'h60);
        chk("sm_mem",      bank[8'h60], ref_mem[8'h60]);

        // Randomized transactions against the reference model
        for (int t = 0; t < 24; t++) begin
            p = 8'($urandom_range(0, 255));
            n = int'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom_range(0, 255));
                w0 = n_wr;
                model_write(7'h42, p, n);
                xfer_write(7'h42, p, n, ack, bm);
                wait_clk(2);
                $display("txn rnd%0d: write ptr=%02h n=%0d reg_addr=%02h", t, p, n, reg_addr);
                chk("rw_ack",      ack,       1);
                chk("rw_wr_cnt",   n_wr - w0, n);
                chk("rw_reg_addr", reg_addr,  ref_ptr);
                for (int i = 0; i < n; i++)
                    chk("rw_mem", bank[8'(p + 8'(i))], ref_mem[8'(p + 8'(i))]);
            end else begin
                r0 = n_rd;
                model_read(p, n);
                do_read(p, n, bm);
                wait_clk(2);
                $display("txn rnd%0d: read ptr=%02h n=%0d reg_addr=%02h", t, p, n, reg_addr);
                for (int i = 0; i < n; i++) chk("rr_byte", rbuf[i], ebuf[i]);
                chk("rr_rd_cnt",   n_rd - r0, n);
                chk("rr_reg_addr", reg_addr,  ref_ptr);
                chk("rr_busy",     busy,      0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
